// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// valid/ready requesters; drives the RAM pins and returns one-cycle responses.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  busy
);

    // state  | meaning
    // IDLE   | no access in flight; accepts a request
    // ACCESS | RAM pins active for the latched request (one cycle)
    // RESP   | response pulse to the owner; accepts the next request
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic                  ptr;
    logic                  owner;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  accept;
    logic                  grant1;
    logic                  sel_we;

    assign accept     = !rst && (state != ACCESS);
    assign grant1     = req1_valid && (!req0_valid || ptr);
    assign req0_ready = accept && req0_valid && !grant1;
    assign req1_ready = accept && grant1;
    assign sel_we     = grant1 ? req1_we : req0_we;

    // The bus is driven only while the registered write enable is high, so a
    // reset drops the driver in the same instant it drops ram_we.
    assign ram_data = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            wdata_q    <= '0;
            ram_addr   <= '0;
            ram_cs     <= 1'b0;
            ram_we     <= 1'b0;
            ram_oe     <= 1'b0;
            busy       <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (req0_ready || req1_ready) begin
                        state    <= ACCESS;
                        owner    <= grant1;
                        ptr      <= !grant1;
                        ram_addr <= grant1 ? req1_addr : req0_addr;
                        wdata_q  <= grant1 ? req1_wdata : req0_wdata;
                        ram_cs   <= 1'b1;
                        ram_we   <= sel_we;
                        ram_oe   <= !sel_we;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state  <= RESP;
                    ram_cs <= 1'b0;
                    ram_we <= 1'b0;
                    ram_oe <= 1'b0;
                    busy   <= 1'b0;
                    if (owner) rsp1_valid <= 1'b1;
                    else       rsp0_valid <= 1'b1;
                    // ram_oe is high exactly for reads; RAM output settled at the falling edge
                    if (ram_oe) begin
                        if (owner) rsp1_rdata <= ram_data;
                        else       rsp0_rdata <= ram_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Two-requester round-robin controller that shares one single_port_sync_ram instance between independent masters, for example instruction fetch and data load/store. It accepts valid/ready requests, sequences the RAM chip-select, write-enable and output-enable pins, and drives or releases the tri-state data bus. It captures read data and returns a one-cycle response pulse to the requester that issued the access.

Parameters:
ADDR_WIDTH, 28, RAM address width; must match the RAM instance.
DATA_WIDTH, 8, RAM data width; must match the RAM instance.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
req0_valid  input  1  requester 0 has a request pending.
req0_ready  output  1  requester 0 request accepted this cycle.
req0_we  input  1  1 = write, 0 = read.
req0_addr  input  ADDR_WIDTH  requester 0 address.
req0_wdata  input  DATA_WIDTH  requester 0 write data.
rsp0_valid  output  1  one-cycle completion pulse for requester 0.
rsp0_rdata  output  DATA_WIDTH  read data for requester 0; valid while rsp0_valid is high.
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  (same as requester 0).
ram_addr  output  ADDR_WIDTH  address to the RAM.
ram_data  inout  DATA_WIDTH  RAM data bus.
ram_cs  output  1  RAM chip select.
ram_we  output  1  RAM write enable.
ram_oe  output  1  RAM output enable.
busy  output  1  high while in ACCESS.

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst is asynchronous and active-high. While rst is high:
  - state = IDLE, priority pointer = 0;
  - ram_cs, ram_we, ram_oe, busy, req*_ready and rsp*_valid all = 0;
  - ram_addr = 0, rsp*_rdata = 0, ram_data = high-Z.
- FSM states: IDLE, ACCESS, RESP.
- Accept window: the block accepts a request only in IDLE or RESP.
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester named by the priority pointer.
  - req<g>_ready is asserted combinationally for the granted requester only. The handshake is the valid&ready cycle.
  - On handshake the block latches we, addr and wdata, moves to ACCESS, and sets the pointer to the other requester.
  - With no valid request: RESP -> IDLE, IDLE holds.
- ACCESS (exactly one cycle):
  - ram_cs = 1, ram_we = latched we, ram_oe = ~latched we, ram_addr = latched addr, busy = 1.
  - ram_data is driven with the latched wdata only when latched we = 1; otherwise it is high-Z.
  - A write commits at the rising edge ending ACCESS.
  - For a read, the RAM updates its output at the mid-cycle falling edge. The block samples ram_data into the owner's rsp_rdata at the rising edge ending ACCESS.
  - Next state is always RESP.
- RESP:
  - rsp<owner>_valid = 1 for exactly one cycle, for both reads and writes.
  - rsp_rdata holds its last read value after a write and until the next read.
  - ram_cs, ram_we and ram_oe = 0; ram_data = high-Z.
  - A new request may be accepted in the same cycle.
- Latency and throughput:
  - Handshake in cycle N -> RAM access in N+1 -> rsp_valid in N+2.
  - Maximum throughput is one access per 2 cycles.
- Bus contention rule: ram_data is never driven by this block when ram_we = 0.
- Requester rules:
  - A requester holds valid, we, addr and wdata stable until ready.
  - Dropping valid before ready is legal; the request is discarded with no side effects.
- Responses have no backpressure. Each requester has at most one outstanding access by construction.
- Reset mid-operation:
  - Reset during ACCESS before the rising edge: the write is not committed and no response is issued.
  - Pins are deasserted immediately (asynchronously).

Test Plan:
- Reset release, no requests for 5 cycles -> ram_cs = ram_we = ram_oe = 0, ram_data = Z, both ready = 0, both rsp_valid = 0.
- Req0 write addr 0x10, data 0xA5, then req0 read addr 0x10 -> write cycle shows ram_cs = 1, ram_we = 1, ram_data = 0xA5; read shows rsp0_valid two cycles after its handshake with rsp0_rdata = 0xA5; rsp1_valid stays 0.
- Both requesters valid continuously for 8 accesses, both reading preloaded addresses -> grants alternate 0,1,0,1,...; each rsp pulse routed to the correct requester; one handshake every 2 cycles.
- Req1 alone for 3 consecutive reads -> granted every accept window with no wait for requester 0; pointer then favours 0 when both are next valid.
- Read of addr 0x20 preceded by a write of 0x3C to 0x20 from the other requester in back-to-back windows -> read returns 0x3C; no cycle shows ram_data driven while ram_we = 0.
- Assert rst in mid-ACCESS of a write 0xFF to 0x30, release, then read 0x30 -> pins drop immediately; read returns the pre-existing value, not 0xFF; no rsp pulse for the aborted access.
